// File: rtl/cmos_capture_rgb565.sv
// rtl/cmos_capture_rgb565.sv - DVP camera byte-pair receiver producing RGB565 pixels with coordinates
module cmos_capture_rgb565 #(
    parameter logic        CMOS_VSYNC_VALID = 1'b1,
    parameter logic [10:0] IMG_HDISP        = 11'd640,
    parameter logic [10:0] IMG_VDISP        = 11'd480,
    parameter logic [3:0]  FRAME_SKIP       = 4'd10
) (
    input  logic        cmos_pclk,
    input  logic        rst,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic        out_vsync,
    output logic        out_href,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [10:0] out_x,
    output logic [10:0] out_y,
    output logic [7:0]  frame_cnt,
    output logic        err_hsize,
    output logic        err_vsize
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_vs;
    logic        r_vs_d;
    logic        r_href;
    logic        r_href_d;
    logic [7:0]  r_data;

    logic [3:0]  r_skip;
    logic        r_en;

    logic        r_phase;
    logic [7:0]  r_hi;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_ovf;

    logic        r_valid;
    logic [15:0] r_out_data;
    logic [10:0] r_out_x;
    logic [10:0] r_out_y;
    logic [7:0]  r_frame_cnt;
    logic        r_err_h;
    logic        r_err_v;

    logic        w_vs_n;
    logic        w_fs;
    logic        w_fe;
    logic        w_active;
    logic        w_close;
    logic        w_hs_bad;
    logic        w_y_full;
    logic [10:0] w_y_after;
    logic        w_ovf_after;
    logic        w_vs_bad;
    logic [10:0] w_x_inc;

    assign w_vs_n   = CMOS_VSYNC_VALID ? r_vs : ~r_vs;
    assign w_fs     = w_vs_n & ~r_vs_d;
    assign w_fe     = ~w_vs_n & r_vs_d;
    assign w_active = (r_state == ACTIVE);

    // A line closes on the href fall, or at frame end if href is still high.
    assign w_close     = w_active & ((r_href_d & ~r_href) | (w_fe & r_href));
    assign w_hs_bad    = (r_x != IMG_HDISP) | r_phase;
    assign w_y_full    = (r_y == IMG_VDISP);
    assign w_y_after   = (w_close & ~w_y_full) ? (r_y + 11'd1) : r_y;
    // Lines beyond IMG_VDISP cannot be counted in y, so remember them separately.
    assign w_ovf_after = r_ovf | (w_close & w_y_full);
    assign w_vs_bad    = (w_y_after != IMG_VDISP) | w_ovf_after;
    assign w_x_inc     = (r_x == 11'h7FF) ? r_x : (r_x + 11'd1);

    // Pin registers; vsync history resets to "in frame" so a reset mid-frame cannot fake a frame start.
    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            r_vs     <= CMOS_VSYNC_VALID;
            r_vs_d   <= 1'b1;
            r_href   <= 1'b0;
            r_href_d <= 1'b0;
            r_data   <= 8'h00;
        end else begin
            r_vs     <= cmos_vsync;
            r_vs_d   <= w_vs_n;
            r_href   <= cmos_href;
            r_href_d <= r_href;
            r_data   <= cmos_data;
        end
    end

    // Frame state register.
    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame state transitions: enter only on frame start, leave on frame end.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_fs) w_state_next = ACTIVE;
            ACTIVE:  if (w_fe) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Start-up frame skip; output enable latches once enough frames have completed.
    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            r_skip <= 4'd0;
            r_en   <= (FRAME_SKIP == 4'd0);
        end else if (w_active && w_fe && (r_skip != FRAME_SKIP)) begin
            r_skip <= r_skip + 4'd1;
            if ((r_skip + 4'd1) == FRAME_SKIP) begin
                r_en <= 1'b1;
            end
        end
    end

    // Byte-pair assembly, line/frame accounting and error pulses.
    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            r_phase     <= 1'b0;
            r_hi        <= 8'h00;
            r_x         <= 11'd0;
            r_y         <= 11'd0;
            r_ovf       <= 1'b0;
            r_valid     <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_x     <= 11'd0;
            r_out_y     <= 11'd0;
            r_frame_cnt <= 8'd0;
            r_err_h     <= 1'b0;
            r_err_v     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err_h <= 1'b0;
            r_err_v <= 1'b0;
            if (!w_active || w_fe) begin
                r_phase <= 1'b0;
                r_x     <= 11'd0;
                r_y     <= 11'd0;
                r_ovf   <= 1'b0;
                if (w_active) begin
                    r_err_h <= w_close & w_hs_bad;
                    r_err_v <= w_vs_bad;
                    if (r_en) begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end
                end
            end else begin
                if (r_href) begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_hi <= r_data;
                    end else begin
                        r_x <= w_x_inc;
                        if (!w_y_full) begin
                            r_out_data <= {r_hi, r_data};
                            r_out_x    <= r_x;
                            r_out_y    <= r_y;
                            r_valid    <= r_en;
                        end
                    end
                end else begin
                    r_phase <= 1'b0;
                end
                if (w_close) begin
                    r_err_h <= w_hs_bad;
                    r_x     <= 11'd0;
                    r_y     <= w_y_after;
                    r_ovf   <= w_ovf_after;
                end
            end
        end
    end

    assign out_vsync = w_active & r_en;
    assign out_href  = w_active & r_en & r_href;
    assign out_valid = r_valid;
    assign out_data  = r_out_data;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign frame_cnt = r_frame_cnt;
    assign err_hsize = r_err_h;
    assign err_vsize = r_err_v;

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// tb/tb_cmos_capture_rgb565.sv - self-checking bench for cmos_capture_rgb565
module tb_cmos_capture_rgb565;

    typedef struct {
        logic [15:0] d;
        logic [10:0] x;
        logic [10:0] y;
    } pix_t;

    typedef struct {
        int nlines;
        int nbytes;
        int exp_hs;
        int exp_vs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        vsync_n;

    logic        a_vsync, a_href, a_valid, a_errh, a_errv;
    logic [15:0] a_data;
    logic [10:0] a_x, a_y;
    logic [7:0]  a_fc;
    logic        b_vsync, b_href, b_valid, b_errh, b_errv;
    logic [15:0] b_data;
    logic [10:0] b_x, b_y;
    logic [7:0]  b_fc;

    int n_checks = 0;
    int n_fail   = 0;

    pix_t qa[$];
    pix_t qb[$];
    int   a_hs = 0, a_vs = 0, b_hs = 0, b_vs = 0;
    int   a_vs_hi = 0, b_vs_hi = 0;
    bit   a_prev = 1'b0, b_prev = 1'b0;
    logic [7:0] fc_a = 8'd0;
    logic [7:0] fc_b = 8'd0;
    int   b_done = 0;
    vec_t vecs[6];

    assign vsync_n = ~vsync;

    always #5 clk = ~clk;

    cmos_capture_rgb565 #(
        .CMOS_VSYNC_VALID(1'b1), .IMG_HDISP(11'd4), .IMG_VDISP(11'd2), .FRAME_SKIP(4'd0)
    ) u_a (
        .cmos_pclk(clk), .rst(rst), .cmos_vsync(vsync), .cmos_href(href), .cmos_data(data),
        .out_vsync(a_vsync), .out_href(a_href), .out_valid(a_valid), .out_data(a_data),
        .out_x(a_x), .out_y(a_y), .frame_cnt(a_fc), .err_hsize(a_errh), .err_vsize(a_errv)
    );

    cmos_capture_rgb565 #(
        .CMOS_VSYNC_VALID(1'b0), .IMG_HDISP(11'd4), .IMG_VDISP(11'd2), .FRAME_SKIP(4'd2)
    ) u_b (
        .cmos_pclk(clk), .rst(rst), .cmos_vsync(vsync_n), .cmos_href(href), .cmos_data(data),
        .out_vsync(b_vsync), .out_href(b_href), .out_valid(b_valid), .out_data(b_data),
        .out_x(b_x), .out_y(b_y), .frame_cnt(b_fc), .err_hsize(b_errh), .err_vsize(b_errv)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitors: pop expected pixels as they appear, count error pulses.
    always @(negedge clk) begin
        pix_t e;
        if (rst) begin
            a_prev = 1'b0;
            b_prev = 1'b0;
        end else begin
            if (a_valid) begin
                check("a_valid_spacing", int'(a_prev), 0);
                if (qa.size() == 0) begin
                    check("a_unexpected_pixel", 1, 0);
                end else begin
                    e = qa.pop_front();
                    check("a_data", int'(a_data), int'(e.d));
                    check("a_x", int'(a_x), int'(e.x));
                    check("a_y", int'(a_y), int'(e.y));
                end
            end
            if (b_valid) begin
                check("b_valid_spacing", int'(b_prev), 0);
                if (qb.size() == 0) begin
                    check("b_unexpected_pixel", 1, 0);
                end else begin
                    e = qb.pop_front();
                    check("b_data", int'(b_data), int'(e.d));
                    check("b_x", int'(b_x), int'(e.x));
                    check("b_y", int'(b_y), int'(e.y));
                end
            end
            a_prev = a_valid;
            b_prev = b_valid;
            if (a_errh) a_hs++;
            if (a_errv) a_vs++;
            if (b_errh) b_hs++;
            if (b_errv) b_vs++;
            if (a_vsync) a_vs_hi++;
            if (b_vsync) b_vs_hi++;
        end
    end

    task automatic send_frame(input int nl, input int nb, input int exp_hs, input int exp_vs);
        bit   eb;
        pix_t p;
        int   ah0, av0, bh0, bv0;
        eb = (b_done >= 2);
        for (int l = 0; l < nl; l++) begin
            for (int k = 0; k < nb / 2; k++) begin
                if (l < 2) begin
                    p.d = {8'(2 * k), 8'(2 * k + 1)};
                    p.x = 11'(k);
                    p.y = 11'(l);
                    qa.push_back(p);
                    if (eb) qb.push_back(p);
                end
            end
        end
        ah0 = a_hs; av0 = a_vs; bh0 = b_hs; bv0 = b_vs;
        a_vs_hi = 0;
        b_vs_hi = 0;
        vsync = 1'b1;
        tick(4);
        for (int l = 0; l < nl; l++) begin
            href = 1'b1;
            for (int i = 0; i < nb; i++) begin
                data = 8'(i);
                tick(1);
            end
            href = 1'b0;
            data = 8'h00;
            tick(4);
        end
        vsync = 1'b0;
        tick(6);
        fc_a = fc_a + 8'd1;
        if (eb) fc_b = fc_b + 8'd1;
        b_done++;
        check("a_frame_cnt", int'(a_fc), int'(fc_a));
        check("b_frame_cnt", int'(b_fc), int'(fc_b));
        check("a_err_hsize_count", a_hs - ah0, exp_hs);
        check("a_err_vsize_count", a_vs - av0, exp_vs);
        check("b_err_hsize_count", b_hs - bh0, exp_hs);
        check("b_err_vsize_count", b_vs - bv0, exp_vs);
        check("a_vsync_seen", int'(a_vs_hi > 0), 1);
        check("b_vsync_seen", int'(b_vs_hi > 0), int'(eb));
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_vsync"}, int'(a_vsync), 0);
        check({tag, "_a_href"}, int'(a_href), 0);
        check({tag, "_a_valid"}, int'(a_valid), 0);
        check({tag, "_a_data"}, int'(a_data), 0);
        check({tag, "_a_xy"}, int'({a_x, a_y}), 0);
        check({tag, "_a_frame_cnt"}, int'(a_fc), 0);
        check({tag, "_a_err"}, int'({a_errh, a_errv}), 0);
        check({tag, "_b_vsync_valid"}, int'({b_vsync, b_valid}), 0);
        check({tag, "_b_frame_cnt"}, int'(b_fc), 0);
    endtask

    initial begin
        vecs[0] = '{nlines: 2, nbytes: 8,  exp_hs: 0, exp_vs: 0};
        vecs[1] = '{nlines: 2, nbytes: 8,  exp_hs: 0, exp_vs: 0};
        vecs[2] = '{nlines: 2, nbytes: 7,  exp_hs: 2, exp_vs: 0};
        vecs[3] = '{nlines: 2, nbytes: 10, exp_hs: 2, exp_vs: 0};
        vecs[4] = '{nlines: 3, nbytes: 8,  exp_hs: 0, exp_vs: 1};
        vecs[5] = '{nlines: 2, nbytes: 8,  exp_hs: 0, exp_vs: 0};

        rst   = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        data  = 8'h00;
        tick(3);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(4);

        foreach (vecs[i]) begin
            send_frame(vecs[i].nlines, vecs[i].nbytes, vecs[i].exp_hs, vecs[i].exp_vs);
        end

        // Reset in the middle of the first line: outputs clear and the partial frame is ignored.
        vsync = 1'b1;
        tick(4);
        href = 1'b1;
        data = 8'h00;
        tick(1);
        data = 8'h01;
        rst  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all_zero("midreset");
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        fc_a    = 8'd0;
        fc_b    = 8'd0;
        b_done  = 0;
        a_vs_hi = 0;
        for (int i = 2; i < 8; i++) begin
            data = 8'(i);
            tick(1);
        end
        href = 1'b0;
        tick(4);
        href = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data = 8'(i);
            tick(1);
        end
        href = 1'b0;
        tick(4);
        vsync = 1'b0;
        tick(6);
        check("partial_frame_vsync", a_vs_hi, 0);
        check("partial_frame_cnt", int'(a_fc), 0);

        send_frame(2, 8, 0, 0);

        // Enough clean frames to carry frame_cnt through 255 -> 0.
        for (int f = 0; f < 256; f++) begin
            send_frame(2, 8, 0, 0);
        end
        check("wrap_frame_cnt", int'(a_fc), 1);

        check("final_qa_empty", qa.size(), 0);
        check("final_qb_empty", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
